// File: rtl/aes_dec_round_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_dec_round_sequencer : iterative AES-128 decrypt controller for an external
// combinational inverse-round datapath. Optional abort input: AES_DEC_ABORT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_dec_round_sequencer #(
  parameter int N_ROUNDS = 10,
  parameter int ITER_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef AES_DEC_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_state,
  input  logic [127:0]      in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_state,
  output logic              busy,
  output logic [3:0]        round_idx,
  output logic [1:0]        dp_sel,
  output logic [127:0]      dp_state_in,
  output logic [127:0]      dp_key_in,
  output logic [ITER_W-1:0] dp_iterate,
  input  logic [127:0]      dp_state_out,
  input  logic [127:0]      dp_key_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_r, key_r;
  logic [3:0]   round_q;
  logic         abort_hit;

`ifdef AES_DEC_ABORT_EN
  assign abort_hit = abort && (fsm_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign out_state   = state_r;
  assign dp_state_in = state_r;
  assign dp_key_in   = key_r;
  assign round_idx   = round_q;

  always_comb begin
    fsm_d      = fsm_q;
    dp_sel     = 2'b11;
    dp_iterate = '0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) fsm_d = S_INIT;
      end
      S_INIT: fsm_d = S_ROUND;
      S_ROUND: begin
        dp_sel     = 2'b00;
        // round-constant index counts down from N_ROUNDS to 2 across the middle rounds
        dp_iterate = ITER_W'(N_ROUNDS + 1) - ITER_W'(round_q);
        if (round_q == 4'(N_ROUNDS - 1)) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        dp_sel     = 2'b01;
        dp_iterate = ITER_W'(1);
        fsm_d      = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      state_r <= '0;
      key_r   <= '0;
      round_q <= '0;
    end else if (abort_hit) begin
      fsm_q   <= S_IDLE;
      state_r <= '0;
      key_r   <= '0;
      round_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            state_r <= in_state;
            key_r   <= in_key;
          end
        end
        S_INIT: begin
          state_r <= dp_state_out;
          round_q <= 4'd1;
        end
        S_ROUND: begin
          state_r <= dp_state_out;
          key_r   <= dp_key_out;
          round_q <= round_q + 4'd1;
        end
        S_FINAL: begin
          state_r <= dp_state_out;
          key_r   <= dp_key_out;
          round_q <= 4'(N_ROUNDS);
        end
        S_DONE: begin
          if (out_ready) round_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
